ip2_test3_result_fifo: RTL
==========================

# ip2_test3_result_fifo

Downstream consumer of the ip2 test3 state machine: detects each completed test3 run via the rising edge of `status_done`, snapshots both 48-bit DNN output captures into a small FIFO for software readout, and, optionally, compares each snapshot against expected patterns under a bit mask, keeping saturating run and mismatch counters. It sits between the test3 state machine outputs and the register/readout fabric, so repeated test3 triggers can run back-to-back without losing results.

## Interface
Parameters:
- `DEPTH`, 8, number of FIFO entries; power of two, range 2 to 64.
- `CNT_W`, 16, width of the run and mismatch counters.

Ports:
- `clk`  in  1  FM clock, 400 MHz, mapped to pl_clk1.
- `reset`  in  1  Asynchronous, active-high reset.
- `enable`  in  1  Capture enable. When low, no new captures; reads still served.
- `clear`  in  1  Synchronous one-cycle flush of FIFO, counters and sticky flags.
- `sm_test3_i_status_done`  in  1  Done flag from the test3 state machine.
- `sm_test3_i_dnn_output_0`  in  48  DNN output 0 capture.
- `sm_test3_i_dnn_output_1`  in  48  DNN output 1 capture.
- `expected_0`, `expected_1`  in  48 each  Expected patterns.
- `compare_mask`  in  48  Bit i = 1 means bit i is compared in both words.
- `rd_en`  in  1  Pop request. Ignored when the FIFO is empty.
- `rd_data_0`, `rd_data_1`  out  48 each  Head entry (show-ahead). Value is 0 when empty.
- `rd_match`  out  1  Match flag stored with the head entry.
- `fifo_empty`, `fifo_full`  out  1 each  FIFO status.
- `fifo_count`  out  $clog2(DEPTH)+1  Number of occupied entries.
- `overflow`  out  1  Sticky. Set when a capture is dropped.
- `run_cnt`  out  CNT_W  Captures accepted or dropped. Saturating.
- `mismatch_cnt`  out  CNT_W  Captures that failed comparison. Saturating.

## Operation
- Edge detect: register `done_d` tracks `sm_test3_i_status_done` every cycle, independent of `enable`. The capture event is `status_done & ~done_d & enable`. A done level held high across an `enable` rising edge does not generate an event.
- Stage 1 (the edge where the event is sampled):
  - Latch both DNN words.
  - Compute `match = ~|((out0^expected_0)&compare_mask) & ~|((out1^expected_1)&compare_mask)`, using inputs sampled at that same edge.
  - Set `s1_valid`.
- Stage 2 (next edge), when `s1_valid` is set:
  - `run_cnt` increments.
  - If `match` is 0, `mismatch_cnt` increments.
  - If the FIFO is not full, or `rd_en` pops in the same cycle, write {data0, data1, match} at the write pointer.
  - Otherwise, drop the capture and set `overflow`.
- Read: on `rd_en` with the FIFO non-empty, the read pointer advances. The new head appears on `rd_data_*` after that edge.
- Pointers: `$clog2(DEPTH)`-bit, wrapping modulo DEPTH. `fifo_count` is updated +1 / -1 / 0; a simultaneous push and pop leaves it unchanged.
- Counters saturate at all-ones and never wrap.
- `clear` takes priority over everything in the same cycle. It zeroes pointers, `fifo_count`, counters, `overflow`, and `s1_valid`, so an in-flight or coincident capture is discarded. `done_d` is still updated.
- Reset values: all outputs 0, except `fifo_empty` = 1. `done_d` = 0, `s1_valid` = 0. The storage array is not reset; `rd_data_*` is masked to 0 while empty.

## Timing
- Latency: a done rising edge sampled at edge k appears on `rd_data_*`, with `fifo_empty` = 0, after edge k+1. Counters also update at edge k+1.
- Throughput: one capture per two cycles minimum. The test3 state machine spacing is far larger than this.
- Full with simultaneous push and pop: both occur, no overflow, `fifo_full` stays 1.
- Empty with `rd_en`: no pointer change and no underflow flag.
- Asynchronous reset mid-pipeline: the pending `s1_valid` capture is lost.

## Configuration
- `IP2_TEST3_RESULT_COMPARE_EN`
  - Defined: the comparator, `mismatch_cnt` and stored `rd_match` are implemented as above.
  - Undefined: the comparator is removed. `match` is constant 1, so `rd_match` = 1 and `mismatch_cnt` = 0. `expected_*` and `compare_mask` are left unconnected internally; the ports remain.

## Test plan
- Single capture: out0 = 48'hA5A5_0000_FFFF, out1 = 48'h1, mask = all-ones, expected equal to the outputs; pulse done.
  - Two edges later: `fifo_count` = 1, `rd_data_0` = 48'hA5A5_0000_FFFF, `rd_match` = 1, `run_cnt` = 1, `mismatch_cnt` = 0.
  - After `rd_en`: empty, `rd_data` = 0.
- Mask: expected_0 differs in bit 47, mask bit 47 = 0 → `rd_match` = 1. Same stimulus with mask = all-ones → `rd_match` = 0, `mismatch_cnt` = 1 (only with the macro defined).
- Overflow with DEPTH = 8: send 9 done pulses with no reads → `fifo_full` = 1, `overflow` = 1, `run_cnt` = 9. The 8 stored entries are pulses 1-8 in order. A 10th pulse coincident with `rd_en` is stored, with no change to full.
- Held done: hold done high for 20 cycles → exactly one capture. Toggle `enable` 0→1 while done is high → no capture.
- Clear coincident with stage 2 of a capture → FIFO empty, `run_cnt` = 0, `overflow` = 0. The next done edge captures normally.
- Asynchronous reset asserted between stage 1 and stage 2 → all outputs at reset values immediately, and no entry appears after reset release.

Source files
------------

// File: rtl/ip2_test3_result_fifo.sv
// ip2_test3_result_fifo: snapshots test3 DNN outputs on each done rising edge into a show-ahead FIFO with optional masked compare
// Ports: clk/reset (async, active high), enable (capture enable), clear (sync flush),
//   sm_test3_i_status_done / sm_test3_i_dnn_output_0/1 (test3 state machine results),
//   expected_0/1 + compare_mask (compare patterns), rd_en (pop), rd_data_0/1 + rd_match (head entry),
//   fifo_empty/fifo_full/fifo_count (status), overflow (sticky drop flag), run_cnt/mismatch_cnt (saturating).
// Optional feature: define IP2_TEST3_RESULT_COMPARE_EN to build the comparator; otherwise every capture matches.
module ip2_test3_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     sm_test3_i_status_done,
  input  logic [47:0]              sm_test3_i_dnn_output_0,
  input  logic [47:0]              sm_test3_i_dnn_output_1,
  input  logic [47:0]              expected_0,
  input  logic [47:0]              expected_1,
  input  logic [47:0]              compare_mask,
  input  logic                     rd_en,
  output logic [47:0]              rd_data_0,
  output logic [47:0]              rd_data_1,
  output logic                     rd_match,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         run_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic             done_q, s1_valid_q, s1_match_q, ovf_q, ovf_d;
  logic [47:0]      s1_d0_q, s1_d1_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] run_q, run_d, mis_q, mis_d;
  logic [96:0]      mem_q [DEPTH];
  logic [96:0]      head;
  logic             cap, match, push, pop;
  assign cap = sm_test3_i_status_done & ~done_q & enable;
`ifdef IP2_TEST3_RESULT_COMPARE_EN
  assign match = ~|((sm_test3_i_dnn_output_0 ^ expected_0) & compare_mask) &
                 ~|((sm_test3_i_dnn_output_1 ^ expected_1) & compare_mask);
`else
  logic unused_cmp;
  assign unused_cmp = ^{expected_0, expected_1, compare_mask};
  assign match = 1'b1;
`endif
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == (AW+1)'(DEPTH);
  assign pop  = rd_en & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  assign push = s1_valid_q & (~fifo_full | pop);
  always_comb begin
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    run_d   = (s1_valid_q & ~&run_q) ? run_q + 1'b1 : run_q;
    mis_d   = (s1_valid_q & ~s1_match_q & ~&mis_q) ? mis_q + 1'b1 : mis_q;
    ovf_d   = ovf_q | (s1_valid_q & ~push);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_match_q <= 1'b0;
      s1_d0_q    <= '0;
      s1_d1_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      run_q      <= '0;
      mis_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= sm_test3_i_status_done;
      if (clear) begin
        s1_valid_q <= 1'b0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        run_q      <= '0;
        mis_q      <= '0;
        ovf_q      <= 1'b0;
      end else begin
        s1_valid_q <= cap;
        if (cap) begin
          s1_d0_q    <= sm_test3_i_dnn_output_0;
          s1_d1_q    <= sm_test3_i_dnn_output_1;
          s1_match_q <= match;
        end
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
        run_q   <= run_d;
        mis_q   <= mis_d;
        ovf_q   <= ovf_d;
      end
    end
  always_ff @(posedge clk)
    if (push & ~clear & ~reset) mem_q[wr_ptr_q] <= {s1_d0_q, s1_d1_q, s1_match_q};
  assign head         = mem_q[rd_ptr_q];
  assign rd_data_0    = fifo_empty ? '0 : head[96:49];
  assign rd_data_1    = fifo_empty ? '0 : head[48:1];
  assign rd_match     = ~fifo_empty & head[0];
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;
  assign run_cnt      = run_q;
  assign mismatch_cnt = mis_q;
endmodule
